alu_result_packer: RTL and testbench

ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

---
 rtl/alu_result_packer_if.sv | 25 ++
 rtl/alu_result_packer.sv | 219 +++++++++++++++++++++
 tb/tb_alu_result_packer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_packer_if.sv
// -----------------------------------------------------------------------------
// alu_result_packer_if
//   Packed-word write bus of alu_result_packer, one lane per result channel.
//   master : the packer, presents the FIFO head word and its valid.
//   slave  : the consumer, returns ready.
//   Signals (per channel):
//     wdata_o  packed word at FIFO head
//     wbe_o    byte enables of the head word
//     waddr_o  word index of the head word within its stream
//     wvld_o   head word valid
//     wrdy_i   consumer ready; head pops when wvld_o && wrdy_i
// -----------------------------------------------------------------------------
interface alu_result_packer_if #(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4
);
    logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] wdata_o;
    logic [PARALLEL_IF_NUM-1:0][3:0]          wbe_o;
    logic [PARALLEL_IF_NUM-1:0][15:0]         waddr_o;
    logic [PARALLEL_IF_NUM-1:0]               wvld_o;
    logic [PARALLEL_IF_NUM-1:0]               wrdy_i;

    modport master (output wdata_o, wbe_o, waddr_o, wvld_o, input wrdy_i);
    modport slave  (input wdata_o, wbe_o, waddr_o, wvld_o, output wrdy_i);
endinterface

// File: rtl/alu_result_packer.sv
// -----------------------------------------------------------------------------
// alu_result_packer
//   Packs a stream of ALU result elements (8/16/32-bit, or single mask bits)
//   into words, one independent packer + FIFO per channel.
//   Optional feature: define ALU_RESULT_PACKER_MASK_EN to enable mask-bit
//   packing; without it mask_op_i is ignored and elements pack by SEW only.
//   Ports:
//     clk, rstn        clock, asynchronous active-low reset
//     start_i          per channel: begin new stream (clears packer, counter,
//                      FIFO and overflow; a same-cycle element is slot 0)
//     alu_vld_i        per channel: element valid (always accepted)
//     alu_result_i     element value, LSB aligned
//     output_sew_i     element width 00=8b 01=16b 10/11=32b
//     mask_op_i        element is a mask bit (bit 0 of alu_result_i)
//     last_i           element ends its stream (flushes a partial word)
//     wr_if            packed-word write bus (master side)
//     overflow_o       sticky: a word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module alu_result_packer #(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [PARALLEL_IF_NUM-1:0]               start_i,
    input  logic [PARALLEL_IF_NUM-1:0]               alu_vld_i,
    input  logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] alu_result_i,
    input  logic [PARALLEL_IF_NUM-1:0][1:0]          output_sew_i,
    input  logic [PARALLEL_IF_NUM-1:0]               mask_op_i,
    input  logic [PARALLEL_IF_NUM-1:0]               last_i,
    alu_result_packer_if.master                      wr_if,
    output logic [PARALLEL_IF_NUM-1:0]               overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [OP_WIDTH-1:0] word_t;

    logic [PARALLEL_IF_NUM-1:0][OP_WIDTH-1:0] wdata;
    logic [PARALLEL_IF_NUM-1:0][3:0]          wbe;
    logic [PARALLEL_IF_NUM-1:0][15:0]         waddr;
    logic [PARALLEL_IF_NUM-1:0]               wvld;

`ifndef ALU_RESULT_PACKER_MASK_EN
    logic unused_mask;
    assign unused_mask = ^mask_op_i;
`endif

    for (genvar ch = 0; ch < PARALLEL_IF_NUM; ch++) begin : g_ch
        // Packing state
        logic [4:0]       slot_q, slot_d;
        word_t            word_q, word_d;
        logic [3:0]       be_q, be_d;
        logic [1:0]       sew_q, sew_d;
        logic [15:0]      cnt_q, cnt_d;
        // FIFO state
        logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CNT_W-1:0] fcnt_q, fcnt_d;
        logic             ovf_q, ovf_d;
        word_t            fifo_data_q [FIFO_DEPTH];
        logic [3:0]       fifo_be_q   [FIFO_DEPTH];
        logic [15:0]      fifo_addr_q [FIFO_DEPTH];
`ifdef ALU_RESULT_PACKER_MASK_EN
        logic             mask_q, mask_d, eff_mask;
`endif
        // start_i-adjusted view of the current state
        logic [4:0]       b_slot;
        word_t            b_word;
        logic [3:0]       b_be;
        logic [15:0]      b_cnt;
        logic [PTR_W-1:0] b_wptr, b_rptr;
        logic [CNT_W-1:0] b_fcnt;
        logic [1:0]       eff_sew;
        word_t            place_data, push_data;
        logic [3:0]       place_be, push_be;
        logic             slot_last, push, pop, full, wr_en;

        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        always_comb begin
            b_slot = start_i[ch] ? '0 : slot_q;
            b_word = start_i[ch] ? '0 : word_q;
            b_be   = start_i[ch] ? '0 : be_q;
            b_cnt  = start_i[ch] ? '0 : cnt_q;
            b_wptr = start_i[ch] ? '0 : wptr_q;
            b_rptr = start_i[ch] ? '0 : rptr_q;
            b_fcnt = start_i[ch] ? '0 : fcnt_q;

            // Mode is taken from the element in slot 0 and held for the word.
            eff_sew = (b_slot == 5'd0) ? output_sew_i[ch] : sew_q;
            if (eff_sew == 2'b11) eff_sew = 2'b10;
`ifdef ALU_RESULT_PACKER_MASK_EN
            eff_mask = (b_slot == 5'd0) ? mask_op_i[ch] : mask_q;
`endif

            place_data = '0;
            place_be   = '0;
            slot_last  = 1'b0;
`ifdef ALU_RESULT_PACKER_MASK_EN
            if (eff_mask) begin
                place_data = word_t'(alu_result_i[ch][0]) << b_slot;
                // A byte is enabled once any of its bits has been written.
                for (int b = 0; b < 4; b++) place_be[b] = (b_slot[4:3] >= 2'(b));
                slot_last  = (b_slot == 5'd31);
            end else
`endif
            begin
                case (eff_sew)
                    2'b00: begin
                        place_data = word_t'(alu_result_i[ch][7:0]) << {b_slot[1:0], 3'b000};
                        place_be   = 4'b0001 << b_slot[1:0];
                        slot_last  = (b_slot[1:0] == 2'd3);
                    end
                    2'b01: begin
                        place_data = word_t'(alu_result_i[ch][15:0]) << {b_slot[0], 4'b0000};
                        place_be   = b_slot[0] ? 4'b1100 : 4'b0011;
                        slot_last  = b_slot[0];
                    end
                    default: begin
                        place_data = alu_result_i[ch];
                        place_be   = 4'b1111;
                        slot_last  = 1'b1;
                    end
                endcase
            end

            push_data = b_word | place_data;
            push_be   = b_be | place_be;
            push      = alu_vld_i[ch] & (slot_last | last_i[ch]);

            slot_d = b_slot;
            word_d = b_word;
            be_d   = b_be;
            cnt_d  = b_cnt;
            sew_d  = sew_q;
`ifdef ALU_RESULT_PACKER_MASK_EN
            mask_d = mask_q;
`endif
            if (alu_vld_i[ch]) begin
                if (b_slot == 5'd0) begin
                    sew_d = eff_sew;
`ifdef ALU_RESULT_PACKER_MASK_EN
                    mask_d = eff_mask;
`endif
                end
                if (push) begin
                    slot_d = '0;
                    word_d = '0;
                    be_d   = '0;
                    cnt_d  = b_cnt + 16'd1;
                end else begin
                    slot_d = b_slot + 5'd1;
                    word_d = push_data;
                    be_d   = push_be;
                end
            end

            // A pop frees the head slot in the same edge, so a full FIFO still accepts.
            pop    = ~start_i[ch] & (fcnt_q != '0) & wr_if.wrdy_i[ch];
            full   = (b_fcnt == CNT_W'(FIFO_DEPTH));
            wr_en  = push & (~full | pop);
            ovf_d  = (start_i[ch] ? 1'b0 : ovf_q) | (push & full & ~pop);
            fcnt_d = b_fcnt + CNT_W'(wr_en) - CNT_W'(pop);
            wptr_d = b_wptr + PTR_W'(wr_en);
            rptr_d = b_rptr + PTR_W'(pop);
        end

        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                slot_q <= '0;
                word_q <= '0;
                be_q   <= '0;
                sew_q  <= '0;
                cnt_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                fcnt_q <= '0;
                ovf_q  <= 1'b0;
`ifdef ALU_RESULT_PACKER_MASK_EN
                mask_q <= 1'b0;
`endif
            end else begin
                slot_q <= slot_d;
                word_q <= word_d;
                be_q   <= be_d;
                sew_q  <= sew_d;
                cnt_q  <= cnt_d;
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                fcnt_q <= fcnt_d;
                ovf_q  <= ovf_d;
`ifdef ALU_RESULT_PACKER_MASK_EN
                mask_q <= mask_d;
`endif
            end
        end

        // NOTE: FIFO storage has no reset; head outputs are gated by the occupancy count, so stale entries never show.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                fifo_data_q[b_wptr] <= push_data;
                fifo_be_q[b_wptr]   <= push_be;
                fifo_addr_q[b_wptr] <= b_cnt;
            end
        end

        assign wvld[ch]       = (fcnt_q != '0);
        assign wdata[ch]      = wvld[ch] ? fifo_data_q[rptr_q] : '0;
        assign wbe[ch]        = wvld[ch] ? fifo_be_q[rptr_q]   : '0;
        assign waddr[ch]      = wvld[ch] ? fifo_addr_q[rptr_q] : '0;
        assign overflow_o[ch] = ovf_q;
    end

    assign wr_if.wdata_o = wdata;
    assign wr_if.wbe_o   = wbe;
    assign wr_if.waddr_o = waddr;
    assign wr_if.wvld_o  = wvld;
endmodule

// File: tb/tb_alu_result_packer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_packer
//   Self-checking bench for alu_result_packer (default parameters). Expected
//   words are queued per channel when stimulus is driven and compared when the
//   DUT presents them with ready high. Mask-packing checks follow
//   ALU_RESULT_PACKER_MASK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_result_packer;
    localparam int NCH = 4;
    localparam int W   = 32;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic [15:0] addr;
    } exp_t;

    typedef struct {
        int          ch;
        logic        st;
        logic [1:0]  sew;
        logic        msk;
        logic        lst;
        logic [31:0] res;
        logic        push;
        logic [31:0] d;
        logic [3:0]  be;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic [NCH-1:0]          start_i, alu_vld_i, mask_op_i, last_i, overflow_o;
    logic [NCH-1:0][W-1:0]   alu_result_i;
    logic [NCH-1:0][1:0]     output_sew_i;

    alu_result_packer_if #(.OP_WIDTH(W), .PARALLEL_IF_NUM(NCH)) wr_if ();

    alu_result_packer #(.OP_WIDTH(W), .PARALLEL_IF_NUM(NCH), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .alu_vld_i    (alu_vld_i),
        .alu_result_i (alu_result_i),
        .output_sew_i (output_sew_i),
        .mask_op_i    (mask_op_i),
        .last_i       (last_i),
        .wr_if        (wr_if),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb [NCH][$];
    logic [15:0] exp_addr [NCH];
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start_i      = '0;
        alu_vld_i    = '0;
        mask_op_i    = '0;
        last_i       = '0;
        alu_result_i = '0;
        output_sew_i = '0;
    endtask

    task automatic set_ch(input int c, input logic st, input logic vld, input logic [1:0] sew,
                          input logic msk, input logic lst, input logic [31:0] res);
        start_i[c]      = st;
        alu_vld_i[c]    = vld;
        output_sew_i[c] = sew;
        mask_op_i[c]    = msk;
        last_i[c]       = lst;
        alu_result_i[c] = res;
    endtask

    task automatic expect_word(input int c, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.data = d;
        e.be   = be;
        e.addr = exp_addr[c];
        sb[c].push_back(e);
        exp_addr[c] = exp_addr[c] + 16'd1;
    endtask

    // Scoreboard: compare every word that is actually handed over.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_if.wvld_o[c] && wr_if.wrdy_i[c]) begin
                    if (sb[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected ch%0d: got word 0x%0h, expected no word", c, wr_if.wdata_o[c]);
                    end else begin
                        e = sb[c].pop_front();
                        check($sformatf("sb_data ch%0d", c), wr_if.wdata_o[c], e.data);
                        check($sformatf("sb_be ch%0d", c),   32'(wr_if.wbe_o[c]), 32'(e.be));
                        check($sformatf("sb_addr ch%0d", c), 32'(wr_if.waddr_o[c]), 32'(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_in();
        wr_if.wrdy_i = '1;
        rstn = 1'b0;
        for (int c = 0; c < NCH; c++) exp_addr[c] = '0;
        #12;
        check("rst_wvld", 32'(wr_if.wvld_o), 32'h0);
        check("rst_ovf",  32'(overflow_o), 32'h0);
        check("rst_wdata0", wr_if.wdata_o[0], 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // ---------------- table-driven single-channel vectors ----------------
        //              ch st  sew    msk   lst   res            push  data           be
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0022, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0044, 1'b1, 32'h4433_2211, 4'hF});
        vecs.push_back('{0, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_AAAA, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_BBBB, 1'b1, 32'hBBBB_AAAA, 4'hF});
        vecs.push_back('{0, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_CCCC, 1'b1, 32'h0000_CCCC, 4'h3});
        vecs.push_back('{0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'hF});
        // mode changes mid-word are ignored; upper result bits are discarded
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b0, 32'hFFFF_FF01, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FF02, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{0, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_0003, 1'b1, 32'h0003_0201, 4'h7});
        vecs.push_back('{0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_00AB, 1'b1, 32'h0000_00AB, 4'h1});
        // start_i with a same-cycle element restarts the stream at slot 0, word 0
        vecs.push_back('{2, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 4'hF});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{2, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_00A1, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00A2, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00A3, 1'b0, 32'h0,          4'h0});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_00A4, 1'b1, 32'hA4A3_A2A1, 4'hF});
`ifndef ALU_RESULT_PACKER_MASK_EN
        // mask_op_i has no effect in this build
        vecs.push_back('{2, 1'b0, 2'b10, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 4'hF});
        vecs.push_back('{2, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_00FF, 1'b1, 32'h0000_00FF, 4'h1});
`endif

        foreach (vecs[i]) begin
            clear_in();
            set_ch(vecs[i].ch, vecs[i].st, 1'b1, vecs[i].sew, vecs[i].msk, vecs[i].lst, vecs[i].res);
            if (vecs[i].st) exp_addr[vecs[i].ch] = '0;
            tick();
            if (vecs[i].push) expect_word(vecs[i].ch, vecs[i].d, vecs[i].be);
            check($sformatf("vec%0d_wvld", i), 32'(wr_if.wvld_o[vecs[i].ch]), 32'(vecs[i].push));
        end
        clear_in();
        tick();
        tick();

`ifdef ALU_RESULT_PACKER_MASK_EN
        // ---------------- mask packing ----------------
        for (int i = 0; i < 10; i++) begin
            clear_in();
            set_ch(2, 1'b0, 1'b1, 2'b00, 1'b1, (i == 9), 32'hFFFF_FFFE | 32'(i % 2 == 0));
            tick();
            if (i == 9) expect_word(2, 32'h0000_0155, 4'h3);
            check($sformatf("mask10_wvld%0d", i), 32'(wr_if.wvld_o[2]), 32'(i == 9));
        end
        for (int i = 0; i < 32; i++) begin
            clear_in();
            set_ch(2, 1'b0, 1'b1, 2'(i), 1'b1, 1'b0, 32'h0000_0001);
            tick();
            if (i == 31) expect_word(2, 32'hFFFF_FFFF, 4'hF);
            if (i == 30 || i == 31) check($sformatf("mask32_wvld%0d", i), 32'(wr_if.wvld_o[2]), 32'(i == 31));
        end
        clear_in();
        tick();
`endif

        // ---------------- overflow on a full FIFO, cleared by start_i ----------------
        wr_if.wrdy_i[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clear_in();
            set_ch(1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h100 + 32'(i));
            tick();
            if (i == 3) check("ovf_not_yet", 32'(overflow_o[1]), 32'h0);
        end
        clear_in();
        check("ovf_set",       32'(overflow_o[1]), 32'h1);
        check("ovf_head_vld",  32'(wr_if.wvld_o[1]), 32'h1);
        check("ovf_head_data", wr_if.wdata_o[1], 32'h100);
        check("ovf_head_addr", 32'(wr_if.waddr_o[1]), 32'h0);
        set_ch(1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        clear_in();
        exp_addr[1] = '0;
        check("ovf_clr",       32'(overflow_o[1]), 32'h0);
        check("start_flush",   32'(wr_if.wvld_o[1]), 32'h0);

        // ---------------- push and pop in the same cycle on a full FIFO ----------------
        for (int i = 0; i < 4; i++) begin
            clear_in();
            set_ch(1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h200 + 32'(i));
            tick();
            expect_word(1, 32'h200 + 32'(i), 4'hF);
        end
        clear_in();
        set_ch(1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h204);
        wr_if.wrdy_i[1] = 1'b1;
        tick();
        expect_word(1, 32'h204, 4'hF);
        clear_in();
        for (int i = 0; i < 6; i++) tick();
        check("full_pushpop_no_ovf", 32'(overflow_o[1]), 32'h0);
        check("full_pushpop_drain",  32'(sb[1].size()), 32'h0);

        // ---------------- reset in the middle of a stream ----------------
        wr_if.wrdy_i[1] = 1'b0;
        set_ch(1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h777);
        set_ch(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h55);
        tick();
        clear_in();
        set_ch(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h66);
        tick();
        clear_in();
        check("pre_rst_ch1_vld", 32'(wr_if.wvld_o[1]), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_wvld",   32'(wr_if.wvld_o), 32'h0);
        check("rst_mid_wdata1", wr_if.wdata_o[1], 32'h0);
        check("rst_mid_wbe1",   32'(wr_if.wbe_o[1]), 32'h0);
        check("rst_mid_waddr1", 32'(wr_if.waddr_o[1]), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wr_if.wrdy_i[1] = 1'b1;
        for (int c = 0; c < NCH; c++) exp_addr[c] = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            set_ch(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'hA1 + 32'(i) * 32'h11);
            tick();
            if (i == 3) expect_word(0, 32'hD4C3_B2A1, 4'hF);
            check($sformatf("post_rst_wvld%0d", i), 32'(wr_if.wvld_o[0]), 32'(i == 3));
        end
        clear_in();
        tick();

        // ---------------- two channels in parallel ----------------
        for (int i = 0; i < 4; i++) begin
            clear_in();
            set_ch(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h10 + 32'(i));
            set_ch(3, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h3000_0000 + 32'(i));
            tick();
            expect_word(3, 32'h3000_0000 + 32'(i), 4'hF);
            if (i == 3) expect_word(0, 32'h1312_1110, 4'hF);
            check($sformatf("par_ch3_vld%0d", i), 32'(wr_if.wvld_o[3]), 32'h1);
            check($sformatf("par_ch0_vld%0d", i), 32'(wr_if.wvld_o[0]), 32'(i == 3));
        end
        clear_in();
        for (int i = 0; i < 4; i++) tick();

        for (int c = 0; c < NCH; c++) check($sformatf("sb_drained ch%0d", c), 32'(sb[c].size()), 32'h0);
        check("final_ovf", 32'(overflow_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
